// File: rtl/dff_pipe_pkg.sv
// dff_pipe_pkg: shared defaults, occupancy width helper and stage record for dff_pipe.
package dff_pipe_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 3;
  typedef struct packed {
    logic                 vld;
    logic [DEF_WIDTH-1:0] data;
  } stage_t;
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/dff_pipe_stage.sv
// dff_pipe_stage: one elastic pipeline register with load enable, flush and sync active-low reset.
module dff_pipe_stage import dff_pipe_pkg::*; #(
  parameter int               WIDTH   = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             flush,
  input  logic             adv,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             vld,
  output logic [WIDTH-1:0] data
);
  always_ff @(posedge clk) begin
    if (!nrst) begin
      vld  <= 1'b0;
      data <= RST_VAL;
    end else if (flush) begin
      vld <= 1'b0;
    end else if (adv) begin
      vld <= in_vld;
      if (in_vld) data <= in_data;
    end
  end
endmodule

// File: rtl/dff_pipe.sv
// dff_pipe: elastic DEPTH-stage register pipeline with valid/ready and bubble collapsing.
// Define DFF_PIPE_OCC_EN to build the registered occupancy counter; otherwise occupancy is 0.
module dff_pipe import dff_pipe_pkg::*; #(
  parameter int               WIDTH   = DEF_WIDTH,
  parameter int               DEPTH   = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [occ_w(DEPTH)-1:0]   occupancy
);
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] data [DEPTH];
  assign in_ready  = adv[0] & ~flush;
  assign out_valid = vld[DEPTH-1];
  assign out_data  = data[DEPTH-1];
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    // A stage advances when any stage from it downstream is empty or the consumer takes the head.
    assign adv[k] = out_ready | ~&vld[DEPTH-1:k];
    if (k == 0) begin : g_head
      dff_pipe_stage #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_stage (
        .clk(clk), .nrst(nrst), .flush(flush), .adv(adv[k]),
        .in_vld(in_valid & in_ready), .in_data(in_data),
        .vld(vld[k]), .data(data[k])
      );
    end else begin : g_body
      dff_pipe_stage #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_stage (
        .clk(clk), .nrst(nrst), .flush(flush), .adv(adv[k]),
        .in_vld(vld[k-1]), .in_data(data[k-1]),
        .vld(vld[k]), .data(data[k])
      );
    end
  end
`ifdef DFF_PIPE_OCC_EN
  logic in_xfer, out_xfer;
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;
  always_ff @(posedge clk) begin
    if (!nrst || flush) occupancy <= '0;
    else if (in_xfer != out_xfer) occupancy <= in_xfer ? occupancy + 1'b1 : occupancy - 1'b1;
  end
`else
  assign occupancy = '0;
`endif
endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: directed scenarios plus randomized traffic against a queue-based model of dff_pipe.
module tb_dff_pipe;
  localparam int D = 3;
  localparam logic [7:0] RV = 8'hA5;
`ifdef DFF_PIPE_OCC_EN
  localparam bit OCC = 1'b1;
`else
  localparam bit OCC = 1'b0;
`endif
  logic       clk = 1'b0, nrst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, out_valid;
  logic [7:0] out_data;
  logic [1:0] occupancy;
  int vectors = 0, errs = 0;
  typedef struct { logic [7:0] d; int p; } ent_t;
  ent_t q[$];
  always #5 clk = ~clk;
  dff_pipe #(.WIDTH(8), .DEPTH(D), .RST_VAL(RV)) dut (
    .clk(clk), .nrst(nrst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );
  function automatic int exp_occ();
    return OCC ? q.size() : 0;
  endfunction
  function automatic logic m_ready();
    return (q.size() < D || out_ready) && !flush;
  endfunction
  function automatic logic m_valid();
    return q.size() > 0 && q[0].p == D - 1;
  endfunction
  // Model: words in order with their stage position; each moves one stage unless blocked ahead.
  task automatic tick();
    logic acc;
    int lim;
    @(posedge clk);
    if (!nrst || flush) q.delete();
    else begin
      acc = in_valid && m_ready();
      if (m_valid() && out_ready) void'(q.pop_front());
      for (int i = 0; i < q.size(); i++) begin
        lim = (i == 0) ? D - 1 : q[i-1].p - 1;
        q[i].p = (q[i].p + 1 < lim) ? q[i].p + 1 : lim;
      end
      if (acc) q.push_back('{in_data, 0});
    end
    #1;
  endtask
  task automatic drain();
    nrst = 1; flush = 0; in_valid = 0; out_ready = 1;
    repeat (D + 1) tick();
  endtask
  task automatic test_reset();
    nrst = 0; flush = 0; in_valid = 0; out_ready = 0;
    repeat (2) tick();
    #1;
    vectors++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got %b exp 0", out_valid); end
    vectors++; if (out_data !== RV) begin errs++; $display("FAIL rst_data got %h exp %h", out_data, RV); end
    vectors++; if (occupancy !== 2'd0) begin errs++; $display("FAIL rst_occ got %0d exp 0", occupancy); end
    nrst = 1; #1;
    vectors++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
  endtask
  task automatic test_streaming();
    logic ev;
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i < 6); in_data = 8'(i + 1); #1;
      ev = (i >= 3 && i <= 8);
      vectors++; if (out_valid !== ev) begin errs++; $display("FAIL stream_valid[%0d] got %b exp %b", i, out_valid, ev); end
      if (ev) begin
        vectors++; if (out_data !== 8'(i - 2)) begin errs++; $display("FAIL stream_data[%0d] got %h exp %h", i, out_data, 8'(i - 2)); end
      end
      tick();
    end
    in_valid = 0;
  endtask
  task automatic test_back_pressure();
    logic [7:0] got[$];
    bit sent = 0;
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_data = 8'h10 + 8'(i < 3 ? i : 3); #1;
      vectors++; if (in_ready !== (i < 3)) begin errs++; $display("FAIL bp_in_ready[%0d] got %b exp %b", i, in_ready, i < 3); end
      tick();
    end
    in_valid = 1; in_data = 8'h13; #1;
    vectors++; if (out_valid !== 1'b1 || out_data !== 8'h10) begin errs++; $display("FAIL bp_hold got %b/%h exp 1/10", out_valid, out_data); end
    vectors++; if (occupancy !== (OCC ? 2'd3 : 2'd0)) begin errs++; $display("FAIL bp_occ got %0d exp %0d", occupancy, OCC ? 3 : 0); end
    for (int n = 0; n < 20 && got.size() < 4; n++) begin
      in_valid = !sent; in_data = 8'h13; out_ready = 1; #1;
      if (out_valid) got.push_back(out_data);
      if (in_valid && in_ready) sent = 1;
      tick();
    end
    in_valid = 0;
    vectors++; if (got.size() != 4) begin errs++; $display("FAIL bp_count got %0d exp 4", got.size()); end
    for (int j = 0; j < got.size(); j++) begin
      vectors++; if (got[j] !== 8'h10 + 8'(j)) begin errs++; $display("FAIL bp_order[%0d] got %h exp %h", j, got[j], 8'h10 + 8'(j)); end
    end
  endtask
  task automatic test_bubble();
    drain();
    out_ready = 0;
    in_valid = 1; in_data = 8'h20; tick();
    in_valid = 0; tick();
    in_valid = 1; in_data = 8'h21; tick();
    in_valid = 0; tick();
    #1;
    vectors++; if (out_valid !== 1'b1 || out_data !== 8'h20) begin errs++; $display("FAIL bub_head got %b/%h exp 1/20", out_valid, out_data); end
    vectors++; if (in_ready !== 1'b1) begin errs++; $display("FAIL bub_in_ready got %b exp 1", in_ready); end
    vectors++; if (occupancy !== (OCC ? 2'd2 : 2'd0)) begin errs++; $display("FAIL bub_occ got %0d exp %0d", occupancy, OCC ? 2 : 0); end
    out_ready = 1; tick(); #1;
    vectors++; if (out_valid !== 1'b1 || out_data !== 8'h21) begin errs++; $display("FAIL bub_next got %b/%h exp 1/21", out_valid, out_data); end
  endtask
  task automatic test_flush();
    drain();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin in_valid = 1; in_data = 8'h30 + 8'(i); tick(); end
    in_data = 8'h33; flush = 1; #1;
    vectors++; if (in_ready !== 1'b0) begin errs++; $display("FAIL fl_in_ready got %b exp 0", in_ready); end
    tick();
    flush = 0; in_valid = 0; #1;
    vectors++; if (out_valid !== 1'b0) begin errs++; $display("FAIL fl_valid got %b exp 0", out_valid); end
    vectors++; if (occupancy !== 2'd0) begin errs++; $display("FAIL fl_occ got %0d exp 0", occupancy); end
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      vectors++; if (out_valid !== 1'b0) begin errs++; $display("FAIL fl_leak[%0d] got %b/%h exp 0", i, out_valid, out_data); end
    end
  endtask
  task automatic test_reset_mid();
    drain();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin in_valid = 1; in_data = 8'h50 + 8'(i); tick(); end
    in_valid = 0; nrst = 0; tick();
    nrst = 1; #1;
    vectors++; if (out_valid !== 1'b0 || out_data !== RV) begin errs++; $display("FAIL mrst_out got %b/%h exp 0/a5", out_valid, out_data); end
    vectors++; if (occupancy !== 2'd0) begin errs++; $display("FAIL mrst_occ got %0d exp 0", occupancy); end
    in_valid = 1; in_data = 8'h40; out_ready = 1; tick();
    in_valid = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++; if (out_valid !== 1'b0) begin errs++; $display("FAIL mrst_early[%0d] got %b exp 0", i, out_valid); end
      tick();
    end
    #1;
    vectors++; if (out_valid !== 1'b1 || out_data !== 8'h40) begin errs++; $display("FAIL mrst_emerge got %b/%h exp 1/40", out_valid, out_data); end
  endtask
  task automatic test_random();
    drain();
    for (int n = 0; n < 400; n++) begin
      nrst = ($urandom_range(0, 49) != 0);
      flush = ($urandom_range(0, 19) == 0);
      in_valid = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data = 8'($urandom);
      #1;
      vectors++; if (out_valid !== m_valid()) begin errs++; $display("FAIL rnd_valid[%0d] got %b exp %b", n, out_valid, m_valid()); end
      if (m_valid()) begin
        vectors++; if (out_data !== q[0].d) begin errs++; $display("FAIL rnd_data[%0d] got %h exp %h", n, out_data, q[0].d); end
      end
      vectors++; if (occupancy !== 2'(exp_occ())) begin errs++; $display("FAIL rnd_occ[%0d] got %0d exp %0d", n, occupancy, exp_occ()); end
      if (nrst) begin
        vectors++; if (in_ready !== m_ready()) begin errs++; $display("FAIL rnd_in_ready[%0d] got %b exp %b", n, in_ready, m_ready()); end
      end
      tick();
    end
    nrst = 1; flush = 0; in_valid = 0;
  endtask
  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_bubble();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/dff_pipe.md
# dff_pipe

Parametrised, elastic register pipeline that generalises the single-bit synchronous-reset D flip-flop. It provides WIDTH-bit data, DEPTH stages, per-stage valid bits and a valid/ready handshake with bubble collapsing. It sits between producer and consumer blocks that need a fixed-depth register delay, and tolerates downstream back-pressure without losing or duplicating data.

## Interface
- WIDTH, 8: data width in bits, ≥1
- DEPTH, 3: number of register stages, ≥1
- RST_VAL, {WIDTH{1'b0}}: value loaded into every data stage on reset
- clk  input  1  rising-edge clock; all state changes on posedge clk
- nrst  input  1  synchronous reset, active-low; sampled on posedge clk
- flush  input  1  synchronous clear of all valid bits
- in_valid  input  1  producer has data on in_data
- in_ready  output  1  pipeline accepts in_data this cycle
- in_data  input  WIDTH  input word
- out_valid  output  1  last stage holds valid data
- out_ready  input  1  consumer accepts out_data this cycle
- out_data  output  WIDTH  last-stage word
- occupancy  output  $clog2(DEPTH+1)  number of valid stages (see Configuration)

## Operation
- Stage k holds data[k] and vld[k]; stage 0 takes input and stage DEPTH-1 drives the outputs.
- Advance rule: adv[DEPTH-1] = !vld[DEPTH-1] | out_ready; adv[k] = !vld[k] | adv[k+1]. The adv chain is combinational and has no registered ready.
- in_ready = adv[0] & !flush.
- On an edge where adv[k]=1: stage k loads from stage k-1, or from in_data/in_valid&in_ready when k=0. Otherwise stage k holds.
- Bubbles collapse: an empty stage loads from upstream even when downstream is stalled.
- Data registers update only when the incoming valid is 1. Empty stages keep stale data, and out_data is defined only while out_valid=1.
- Transfer occurs on the input when in_valid&in_ready and on the output when out_valid&out_ready.
- flush=1: all vld cleared at the next edge. Input is not accepted and the output transfer in that cycle is still counted as taken by the consumer. Data registers are untouched.
- nrst=0 (priority over flush and handshake): all vld←0, all data←RST_VAL, occupancy←0 at the next edge. This applies mid-stream and loses in-flight data.

## Timing
- Reset values: out_valid=0, out_data=RST_VAL, occupancy=0. in_ready=1 once nrst=1 and flush=0.
- Latency: a word accepted at edge N appears with out_valid=1 after edge N+DEPTH-1, i.e. DEPTH cycles from presentation to output with no stalls.
- Throughput: 1 word/cycle with out_ready held high.
- Full (all vld=1) with out_ready=0: in_ready=0, and all stages and out_data hold.
- Full with out_ready=1: in_ready=1, so simultaneous in/out transfer keeps the pipeline full.
- Empty: out_valid=0, and out_ready is ignored.
- in_ready depends combinationally on out_ready; the producer must not make in_valid depend on in_ready.

## Configuration
- DFF_PIPE_OCC_EN defined: occupancy is a registered counter.
  - +1 on input transfer only, −1 on output transfer only, unchanged on both or neither.
  - Cleared to 0 by flush or nrst.
  - Never exceeds DEPTH and never wraps below 0.
- DFF_PIPE_OCC_EN undefined: the counter is not built and occupancy is tied to 0. The port list is unchanged.

## Structure
- Package dff_pipe_pkg holds:
  - the default WIDTH/DEPTH constants;
  - the occupancy width function (clog2(DEPTH+1));
  - a stage struct typedef {vld, data}.
- Sub-module dff_pipe_stage: one stage register with its load enable (adv) and synchronous active-low reset to RST_VAL. It is instantiated DEPTH times in a generate loop.
- The adv chain and counter live in the top level.

## Test plan
With WIDTH=8, DEPTH=3, RST_VAL=8'hA5:
- Reset: hold nrst=0 for 2 cycles → out_valid=0, out_data=8'hA5, occupancy=0, in_ready=1 after release.
- Streaming: push 8'h01..8'h06 on consecutive cycles with out_ready=1 → first output 8'h01 three cycles after the first push, then one word per cycle in order, with no gaps.
- Back-pressure: push 8'h10, 8'h11, 8'h12, 8'h13 with out_ready=0 →
  - in_ready drops after 3 accepts;
  - out_data=8'h10 held and occupancy=3;
  - raise out_ready → 8'h10..8'h13 delivered in order, with no loss or duplication.
- Bubble collapse: push 8'h20, idle 1 cycle, push 8'h21, with out_ready=0 → both stored in adjacent stages, occupancy=2, in_ready=1.
- Flush: fill with 8'h30..8'h32, assert flush while in_valid=1 carrying 8'h33 →
  - the next cycle has out_valid=0 and occupancy=0;
  - 8'h33 is not accepted.
- Reset mid-stream: drop nrst while full → next edge gives out_valid=0, out_data=8'hA5, occupancy=0; a subsequent push of 8'h40 emerges after 3 cycles.
